// File: rtl/dmem_responder.sv
// Single-port data memory responder: one request at a time, fixed wait cycles,
// registered read data and one-cycle MemReady / MemErr pulses.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [31:0]       write_data_DMEM,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [31:0]       data_DMEM,
  output logic              MemReady,
  output logic              MemErr
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_err;
  logic [31:0]         r_mem [0:DEPTH-1];

  logic w_req_ok, w_req_bad, w_access;

  assign w_req_ok  = MemRead ^ MemWrite;
  assign w_req_bad = MemRead & MemWrite;
  assign w_access  = (r_state == BUSY) && (r_cnt == 4'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_ok) begin
            r_addr  <= address_DMEM;
            r_wdata <= write_data_DMEM;
            r_we    <= MemWrite;
            r_cnt   <= WAIT_INIT;
            r_state <= BUSY;
          end else if (w_req_bad) begin
            r_err <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_we) r_rdata <= r_mem[r_addr];
            r_ready <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory is never reset; an async reset forces IDLE, so an aborted write never lands.
  always_ff @(posedge CLK) begin
    if (w_access && r_we && !RST) r_mem[r_addr] <= r_wdata;
  end

  assign data_DMEM = r_rdata;
  assign MemReady  = r_ready;
  assign MemErr    = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (WAIT_CYCLES 0, 1, 3) driven independently and checked
// against a word-array memory model with cycle-exact MemReady timing.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rd [3];
  logic        wr [3];
  logic [9:0]  ad [3];
  logic [31:0] wd [3];
  logic [31:0] dq [3];
  logic        rdy [3];
  logic        err [3];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mm [3][1024];
  logic [31:0] rq [3];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
      .CLK(CLK), .RST(RST),
      .address_DMEM(ad[g]), .write_data_DMEM(wd[g]),
      .MemWrite(wr[g]), .MemRead(rd[g]),
      .data_DMEM(dq[g]), .MemReady(rdy[g]), .MemErr(err[g])
    );
  end

  function automatic int wc(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on DUT d; request is driven in cycle c, MemReady expected only in c+W+2.
  // With hold=1 the request stays asserted through the following IDLE cycle.
  task automatic xact(input int d, input bit isw, input logic [9:0] a, input logic [31:0] v,
                      input bit hold, input bit scramble, input string tag);
    int w;
    w = wc(d);
    ad[d] = a; wd[d] = v; wr[d] = isw; rd[d] = !isw;
    for (int k = 1; k <= w + 2; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (k == 1 && scramble) begin
        ad[d] = a ^ 10'd4;
        wd[d] = ~v;
      end
      chk($sformatf("%s d%0d rdy k%0d", tag, d, k), 32'(rdy[d]), 32'(k == w + 2));
      chk($sformatf("%s d%0d err k%0d", tag, d, k), 32'(err[d]), 32'd0);
      if (k < w + 2) chk($sformatf("%s d%0d hold k%0d", tag, d, k), dq[d], rq[d]);
    end
    if (isw) mm[d][a] = v;
    else     rq[d] = mm[d][a];
    chk($sformatf("%s d%0d data", tag, d), dq[d], rq[d]);
    if (!hold) begin rd[d] = 1'b0; wr[d] = 1'b0; end
    @(posedge CLK); @(negedge CLK);
    chk($sformatf("%s d%0d idle rdy", tag, d), 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    int held_d;
    for (int d = 0; d < 3; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0; rq[d] = 32'd0;
    end
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset data d%0d", d), dq[d], 32'd0);
      chk($sformatf("reset rdy d%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset err d%0d", d), 32'(err[d]), 32'd0);
    end
    RST = 1'b0;

    // Known contents for every address later read
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 16; a++) xact(d, 1'b1, 10'(a), $urandom, 1'b0, 1'b0, "init");
      xact(d, 1'b1, 10'd1023, $urandom, 1'b0, 1'b0, "init");
    end

    xact(1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 1'b0, "wr5");
    xact(1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, "rd5");
    chk("rd5 value", dq[1], 32'hDEADBEEF);

    // Both strobes high in IDLE: error pulse only
    ad[0] = 10'd6; wd[0] = 32'hFFFF0000; rd[0] = 1'b1; wr[0] = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("err pulse", 32'(err[0]), 32'd1);
    chk("err no rdy", 32'(rdy[0]), 32'd0);
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("err one cycle", 32'(err[0]), 32'd0);
    chk("err no rdy2", 32'(rdy[0]), 32'd0);
    chk("err data kept", dq[0], rq[0]);
    xact(0, 1'b0, 10'd6, 32'd0, 1'b0, 1'b0, "err mem kept");

    xact(1, 1'b0, 10'd3, 32'd0, 1'b0, 1'b1, "addr chg");
    chk("addr chg is addr3", dq[1], mm[1][3]);

    xact(1, 1'b1, 10'd1023, 32'hA5A5A5A5, 1'b0, 1'b0, "wr1023");
    xact(1, 1'b1, 10'd0, 32'h5A5A5A5A, 1'b0, 1'b0, "wr0");
    xact(1, 1'b0, 10'd1023, 32'd0, 1'b0, 1'b0, "rd1023");
    chk("rd1023 value", dq[1], 32'hA5A5A5A5);
    xact(1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, "rd0");
    chk("rd0 value", dq[1], 32'h5A5A5A5A);

    // Back-to-back reads with the request never dropped
    for (int i = 0; i < 4; i++) xact(1, 1'b0, 10'(i + 8), 32'd0, i < 3, 1'b0, "b2b");
    for (int i = 0; i < 4; i++) xact(0, 1'b0, 10'(i + 1), 32'd0, i < 3, 1'b0, "b2b");

    // Reset while the W=3 write has its counter at 2
    ad[2] = 10'd9; wd[2] = 32'h12345678; wr[2] = 1'b1;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort data d%0d", d), dq[d], 32'd0);
      chk($sformatf("abort rdy d%0d", d), 32'(rdy[d]), 32'd0);
      rq[d] = 32'd0;
    end
    wr[2] = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("abort in reset rdy", 32'(rdy[2]), 32'd0);
    RST = 1'b0;
    xact(2, 1'b0, 10'd9, 32'd0, 1'b0, 1'b0, "abort mem kept");
    xact(1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, "post rst mem");
    chk("post rst deadbeef", dq[1], 32'hDEADBEEF);

    // Random traffic
    held_d = -1;
    for (int i = 0; i < 60; i++) begin
      int d;
      bit h;
      d = int'($urandom_range(0, 2));
      if (held_d >= 0 && held_d != d) begin rd[held_d] = 1'b0; wr[held_d] = 1'b0; end
      h = bit'($urandom_range(0, 1));
      xact(d, bit'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, h,
           bit'($urandom_range(0, 1)), "rand");
      held_d = h ? d : -1;
    end
    for (int d = 0; d < 3; d++) begin rd[d] = 1'b0; wr[d] = 1'b0; end
    @(posedge CLK); @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
